instruction_fetch_unit: RTL

// - IF stage of the RV64 pipeline. Holds the PC and issues in-order word fetches to instruction memory.
// - Buffers returned words with their PCs and presents {instruction, pc} to the decode stage.
// - The decode stage drives the immediate generator and the register file.
// - Supports decode back-pressure and a redirect (branch/jump) that flushes all younger fetches.

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and decode handoff.
// The master side is the fetch unit; the slave side is the memory/decode environment.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [63:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV64 IF stage: in-order word fetch with credit-limited buffering of {pc, instr}
// and redirect flushing that drops responses still in flight.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  instruction_fetch_unit_if.master bus
);
  localparam int             PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int             CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [31:0]    NOP   = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [63:0]      fetch_pc, resp_pc, redirect_base;
  logic [CNT_W-1:0] outstanding, outstanding_d, drop_cnt, drop_cnt_d, occupancy;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [63:0]      buf_pc    [BUF_DEPTH];
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic             req_fire, resp_fire, push, pop, head_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign redirect_base = bus.redirect_pc & ~64'h3;

  // Credit: buffered plus in-flight words never exceed the buffer depth.
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (state_q == RUN) &&
                              (({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH);
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_fire  = bus.imem_resp_valid;
  assign head_valid = (occupancy != '0);
  assign push       = resp_fire && (state_q == RUN) && !bus.redirect_valid;
  assign pop        = head_valid && bus.id_ready && !bus.redirect_valid;

  always_comb begin
    outstanding_d = outstanding;
    drop_cnt_d    = drop_cnt;
    if (req_fire && !resp_fire)      outstanding_d = outstanding + CNT_W'(1);
    else if (!req_fire && resp_fire) outstanding_d = outstanding - CNT_W'(1);
    // A redirect turns everything still in flight (after this cycle's response) into drops.
    if (bus.redirect_valid)                   drop_cnt_d = outstanding_d;
    else if (resp_fire && state_q == DRAIN)   drop_cnt_d = drop_cnt - CNT_W'(1);
    state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      occupancy   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding_d;
      drop_cnt    <= drop_cnt_d;
      if (bus.redirect_valid) begin
        fetch_pc  <= redirect_base;
        resp_pc   <= redirect_base;
        occupancy <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (push) begin
          resp_pc <= resp_pc + 64'd4;
          wr_ptr  <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      occupancy <= occupancy + CNT_W'(1);
        else if (!push && pop) occupancy <= occupancy - CNT_W'(1);
      end
    end
  end

  // Buffer payload carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= resp_pc;
      buf_instr[wr_ptr] <= bus.imem_resp_data;
    end
  end

  assign bus.id_valid       = head_valid;
  assign bus.id_instruction = head_valid ? buf_instr[rd_ptr] : NOP;
  assign bus.id_pc          = head_valid ? buf_pc[rd_ptr] : 64'h0;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && occupancy == CNT_W'(BUF_DEPTH)));
endmodule
